// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with shared memory port and memory-wait timeout
//
// Sequences fetch/decode/execute/memory/writeback for lw, sw, beq, ori, R-type,
// jrsal, baln and jmnor over one shared memory port and one ALU. Waits on the
// memory handshake in FETCH/MEMRD/MEMWR/JMNOR_RD and aborts to FETCH when the
// wait reaches MEM_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode, funct         instruction fields, sampled in DECODE only
//   zero                  ALU zero flag (consumed by the datapath through pcwritecond)
//   nsignal_q             registered negative flag, baln condition
//   mem_ready             memory completes the current access this cycle
//   pcwrite .. alusrca    1-bit datapath enables/selects
//   memtoreg, regdst, alusrcb, aluop, pcsource   2-bit mux selects
//   instr_done            one-cycle pulse on instruction retire
//   mem_err               one-cycle pulse on memory timeout
//   state_o               current state encoding
module multicycle_ctrl #(
  parameter logic [5:0] JMNOR_FUNCT = 6'h27,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       nsignal_q,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] memtoreg,
  output logic [1:0] regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       mem_err,
  output logic [3:0] state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRSAL = 6'b010001;
  localparam logic [5:0] OP_BALN  = 6'b011001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BEQ      = 4'd8,
    S_ORIEX    = 4'd9,
    S_ORIWB    = 4'd10,
    S_JRSAL    = 4'd11,
    S_BALN     = 4'd12,
    S_JMNOR_A  = 4'd13,
    S_JMNOR_RD = 4'd14,
    S_JMNOR_J  = 4'd15
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          is_lw;
  logic          mem_state;
  logic          timeout;

  // The branch comparison itself happens in the datapath (pcwritecond & zero),
  // so the flag is not needed here.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) ||
                     (state == S_MEMWR) || (state == S_JMNOR_RD);

  // A ready on the timeout cycle is a normal completion, hence the !mem_ready term.
  assign timeout = mem_state && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT));

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      is_lw    <= 1'b0;
    end else begin
      state <= state_nx;
      // Every way out of a memory state (completion, timeout) and every
      // non-memory state leaves the counter at zero, so entry always starts clean.
      if (mem_state && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      // MEMADR needs lw/sw after the opcode is no longer guaranteed stable.
      if (state == S_DECODE)
        is_lw <= (opcode == OP_LW);
    end
  end

  always_comb begin
    state_nx    = state;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    memtoreg    = 2'b00;
    regdst      = 2'b00;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    mem_err     = 1'b0;

    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = (funct == JMNOR_FUNCT) ? S_JMNOR_A : S_EXEC;
          OP_BEQ:       state_nx = S_BEQ;
          OP_ORI:       state_nx = S_ORIEX;
          OP_JRSAL:     state_nx = S_JRSAL;
          OP_BALN:      state_nx = S_BALN;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        state_nx = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 2'b01;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca  = 1'b1;
        aluop    = 2'b10;
        state_nx = S_RWB;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 2'b01;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
        state_nx    = S_FETCH;
      end
      S_ORIEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluop    = 2'b11;
        state_nx = S_ORIWB;
      end
      S_ORIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_JRSAL: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b11;
        regwrite   = 1'b1;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BALN: begin
        // Link and branch only when negative; the instruction retires either way.
        pcwrite    = nsignal_q;
        regwrite   = nsignal_q;
        pcsource   = 2'b01;
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_JMNOR_A: begin
        alusrca  = 1'b1;
        aluop    = 2'b11;
        state_nx = S_JMNOR_RD;
      end
      S_JMNOR_RD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nx = S_JMNOR_J;
      end
      S_JMNOR_J: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase

    // Abort: drop every architectural write this cycle and restart from fetch.
    if (timeout) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      mem_err  = 1'b1;
      state_nx = S_FETCH;
    end
  end

endmodule
